// File: rtl/dict_buffer_mw.sv
// dict_buffer_mw: multi-lane circular compression dictionary with flattened read-out, valid mask and count.
// Optional registered lookup comparator enabled by defining DICT_MATCH_EN.
module dict_buffer_mw #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int LANES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_clear,
  input  logic [LANES-1:0]              i_wr_en,
  input  logic [LANES*DATA_WIDTH-1:0]   i_wr_data,
  output logic [DEPTH*DATA_WIDTH-1:0]   o_r_data,
  output logic [DEPTH-1:0]              o_valid,
  output logic [$clog2(DEPTH)-1:0]      o_wr_ptr,
  output logic [$clog2(DEPTH+1)-1:0]    o_count,
  output logic                          o_wrap
`ifdef DICT_MATCH_EN
  ,
  input  logic                          i_lookup_valid,
  input  logic [DATA_WIDTH-1:0]         i_lookup_data,
  output logic                          o_hit,
  output logic [$clog2(DEPTH)-1:0]      o_hit_idx
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = PW + 2;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [SW-1:0]         w_k;
  logic                  w_run;
  logic [SW-1:0]         w_sum;
  logic [PW-1:0]         w_ptr_nxt;
  logic [CW:0]           w_cnt_sum;
  logic [CW-1:0]         w_cnt_nxt;
  logic [PW-1:0]         w_slot [LANES];
  // k counts only the unbroken run of enables starting at lane 0
  always_comb begin
    w_k = '0;
    w_run = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      w_run = w_run & i_wr_en[j];
      w_k = w_k + SW'(w_run);
    end
  end
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [SW-1:0] w_lane;
    assign w_lane = SW'(r_wr_ptr) + SW'(j);
    assign w_slot[j] = PW'(w_lane >= SW'(DEPTH) ? w_lane - SW'(DEPTH) : w_lane);
  end
  always_comb begin
    w_sum = SW'(r_wr_ptr) + w_k;
    w_ptr_nxt = PW'(w_sum >= SW'(DEPTH) ? w_sum - SW'(DEPTH) : w_sum);
    w_cnt_sum = {1'b0, r_count} + (CW+1)'(w_k);
    w_cnt_nxt = w_cnt_sum >= (CW+1)'(DEPTH) ? CW'(DEPTH) : CW'(w_cnt_sum);
    o_wrap = (w_k != '0) && (w_sum >= SW'(DEPTH));
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid <= '0;
      r_wr_ptr <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_valid <= '0;
      r_wr_ptr <= '0;
      r_count <= '0;
    end else begin
      for (int j = 0; j < LANES; j++) begin
        if (SW'(j) < w_k) begin
          r_mem[w_slot[j]] <= i_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
          r_valid[w_slot[j]] <= 1'b1;
        end
      end
      r_wr_ptr <= w_ptr_nxt;
      r_count <= w_cnt_nxt;
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_out
    assign o_r_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i];
  end
  assign o_valid = r_valid;
  assign o_wr_ptr = r_wr_ptr;
  assign o_count = r_count;
`ifdef DICT_MATCH_EN
  logic          r_hit;
  logic [PW-1:0] r_hit_idx;
  logic          w_hit;
  logic [PW-1:0] w_hit_idx;
  // descending scan leaves the lowest matching index; sees pre-write state
  always_comb begin
    w_hit = 1'b0;
    w_hit_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (r_valid[i] && r_mem[i] == i_lookup_data) begin
        w_hit = 1'b1;
        w_hit_idx = PW'(i);
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_hit <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      r_hit <= i_lookup_valid && w_hit;
      r_hit_idx <= i_lookup_valid ? w_hit_idx : '0;
    end
  end
  assign o_hit = r_hit;
  assign o_hit_idx = r_hit_idx;
`endif
endmodule

// File: tb/tb_dict_buffer_mw.sv
// tb_dict_buffer_mw: directed and randomized checks of dict_buffer_mw against a behavioural dictionary model.
module tb_dict_buffer_mw;
  localparam int D = 16;
  localparam int W = 32;
  logic clk = 1'b0;
  logic i_reset = 1'b0, i_clear = 1'b0;
  logic [1:0] i_wr_en = '0;
  logic [2*W-1:0] i_wr_data = '0;
  logic [D*W-1:0] o_r_data;
  logic [D-1:0] o_valid;
  logic [3:0] o_wr_ptr;
  logic [4:0] o_count;
  logic o_wrap;
  logic i_lookup_valid = 1'b0;
  logic [W-1:0] i_lookup_data = '0;
  logic o_hit;
  logic [3:0] o_hit_idx;
  int checks = 0, errors = 0;
  logic chk_on = 1'b0;
  logic last_wrap;
  logic [W-1:0] m_mem [D];
  logic [D-1:0] m_valid = '0;
  int m_ptr = 0, m_count = 0, m_idx = 0;
  logic m_hit = 1'b0;
  logic [D*W-1:0] e_flat;

  dict_buffer_mw dut (
    .i_clk(clk), .i_reset(i_reset), .i_clear(i_clear), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .o_r_data(o_r_data), .o_valid(o_valid), .o_wr_ptr(o_wr_ptr), .o_count(o_count), .o_wrap(o_wrap)
`ifdef DICT_MATCH_EN
    , .i_lookup_valid(i_lookup_valid), .i_lookup_data(i_lookup_data), .o_hit(o_hit), .o_hit_idx(o_hit_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [D*W-1:0] a, input logic [D*W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  function automatic int lead_k(input logic [1:0] en);
    int k = 0;
    for (int j = 0; j < 2; j++) begin
      if (!en[j]) break;
      k++;
    end
    return k;
  endfunction

  function automatic logic [W-1:0] word(input int i);
    return o_r_data[i*W +: W];
  endfunction

  task automatic model_update();
    int k;
    if (i_reset) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_valid = '0; m_ptr = 0; m_count = 0; m_hit = 1'b0; m_idx = 0;
    end else if (i_clear) begin
      m_valid = '0; m_ptr = 0; m_count = 0; m_hit = 1'b0; m_idx = 0;
    end else begin
      m_hit = 1'b0; m_idx = 0;
      if (i_lookup_valid)
        for (int i = D-1; i >= 0; i--)
          if (m_valid[i] && m_mem[i] == i_lookup_data) begin m_hit = 1'b1; m_idx = i; end
      k = lead_k(i_wr_en);
      for (int j = 0; j < k; j++) begin
        m_mem[(m_ptr + j) % D] = i_wr_data[j*W +: W];
        m_valid[(m_ptr + j) % D] = 1'b1;
      end
      m_ptr = (m_ptr + k) % D;
      m_count = (m_count + k > D) ? D : m_count + k;
    end
  endtask

  task automatic step(input logic [1:0] en, input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic clr = 1'b0, input logic rst = 1'b0,
                      input logic lv = 1'b0, input logic [W-1:0] ld = '0);
    i_wr_en = en; i_wr_data = {d1, d0}; i_clear = clr; i_reset = rst;
    i_lookup_valid = lv; i_lookup_data = ld;
    #1 last_wrap = o_wrap;
    @(posedge clk);
    model_update();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < D; i++) e_flat[i*W +: W] = m_mem[i];
      chk("data", o_r_data, e_flat);
      chk("valid", o_valid, m_valid);
      chk("ptr", o_wr_ptr, m_ptr);
      chk("count", o_count, m_count);
      chk("wrap", o_wrap, lead_k(i_wr_en) > 0 && m_ptr + lead_k(i_wr_en) >= D);
`ifdef DICT_MATCH_EN
      chk("hit", o_hit, m_hit);
      chk("hit_idx", o_hit_idx, m_idx);
`endif
    end
  end

  initial begin
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    step(2'b00, 0, 0, 0, 1);
    chk_on = 1'b1;
    chk("rst_ptr", o_wr_ptr, 0);
    chk("rst_count", o_count, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_r_data, 0);
    for (int i = 0; i < 16; i++) begin
      step(2'b01, 32'hA0 + i, 0);
      chk("fill_count", o_count, i + 1);
      chk("fill_wrap", last_wrap, i == 15);
    end
    chk("fill_ptr", o_wr_ptr, 0);
    chk("fill_valid", o_valid, 16'hFFFF);
    chk("fill_slot5", word(5), 32'hA5);
    step(2'b01, 32'hB0, 0);
    chk("sat_count", o_count, 16);
    chk("sat_ptr", o_wr_ptr, 1);
    chk("ovw_slot0", word(0), 32'hB0);
    for (int s = 1; s < 15; s++) step(2'b01, 32'hC0 + s, 0);
    chk("pre_ptr15", o_wr_ptr, 15);
    step(2'b11, 32'h11, 32'h22);
    chk("dual_wrap", last_wrap, 1);
    chk("dual_ptr", o_wr_ptr, 1);
    chk("dual_slot15", word(15), 32'h11);
    chk("dual_slot0", word(0), 32'h22);
    step(2'b01, 32'hD1, 0);
    step(2'b01, 32'hD2, 0);
    step(2'b10, 32'hE0, 32'hEE);
    chk("nt_wrap", last_wrap, 0);
    chk("nt_ptr", o_wr_ptr, 3);
    chk("nt_slot3", word(3), 32'hC3);
    chk("nt_slot4", word(4), 32'hC4);
    step(2'b00, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(2'b01, 32'h70 + i, 0);
    chk("pre_clr_ptr", o_wr_ptr, 7);
    chk("pre_clr_count", o_count, 7);
    step(2'b11, 32'h98, 32'h99, 1);
    chk("clr_ptr", o_wr_ptr, 0);
    chk("clr_count", o_count, 0);
    chk("clr_valid", o_valid, 0);
    chk("clr_slot7", word(7), 32'hC7);
    chk("clr_slot0", word(0), 32'h70);
    for (int i = 0; i < 5; i++) step(2'b01, 32'h80 + i, 0);
    chk("pre_rst_ptr", o_wr_ptr, 5);
    step(2'b11, 32'h5A, 32'h5B, 0, 1);
    chk("mrst_ptr", o_wr_ptr, 0);
    chk("mrst_count", o_count, 0);
    chk("mrst_valid", o_valid, 0);
    chk("mrst_data", o_r_data, 0);
`ifdef DICT_MATCH_EN
    for (int s = 0; s < 10; s++) step(2'b01, (s == 2 || s == 9) ? 32'h55 : 32'h100 + s, 0);
    step(2'b00, 0, 0, 0, 0, 1, 32'h55);
    chk("lk_hit", o_hit, 1);
    chk("lk_idx", o_hit_idx, 2);
    step(2'b00, 0, 0, 1);
    step(2'b00, 0, 0, 0, 0, 1, 32'h55);
    chk("lk_clr_hit", o_hit, 0);
    chk("lk_clr_idx", o_hit_idx, 0);
`endif
    for (int c = 0; c < 2000; c++) begin
      logic [W-1:0] a, b, l;
      a = ($urandom_range(3) == 0) ? W'($urandom_range(7)) : W'($urandom);
      b = ($urandom_range(3) == 0) ? W'($urandom_range(7)) : W'($urandom);
      l = ($urandom_range(1) == 0) ? m_mem[$urandom_range(D-1)] : W'($urandom_range(7));
      step(2'($urandom_range(3)), a, b, $urandom_range(39) == 0, $urandom_range(199) == 0,
           1'($urandom_range(1)), l);
    end
    step(2'b00, 0, 0);
    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dict_buffer_mw.md
Name: dict_buffer_mw

Overview:
- Multi-lane, parametrised compression-dictionary buffer: the next generation of the single-entry, two-port dictionary FIFO.
- Accepts 1..LANES words per cycle into a circular DEPTH-word dictionary.
- Exposes the full dictionary flattened for parallel compare logic, plus a per-word valid mask, occupancy count and a wrap indication.
- Sits between the compressor word-classification stage and the dictionary match comparators.

Parameters:
- DATA_WIDTH, 32, bits per dictionary word.
- DEPTH, 16, words in dictionary; any value >= 2, not required to be a power of two.
- LANES, 2, max words written per cycle; 1 <= LANES <= DEPTH.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous active-high reset.
- i_clear  input  1  synchronous dictionary flush (start of new block).
- i_wr_en  input  LANES  per-lane write enable; lane 0 is oldest word.
- i_wr_data  input  LANES*DATA_WIDTH  lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- o_r_data  output  DEPTH*DATA_WIDTH  word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- o_valid  output  DEPTH  bit i set once word i written since last reset/clear.
- o_wr_ptr  output  clog2(DEPTH)  next slot to write.
- o_count  output  clog2(DEPTH+1)  words written since reset/clear, saturating at DEPTH.
- o_wrap  output  1  combinational: current cycle's write fills slot DEPTH-1 (pointer wraps).

Behaviour:
- One clock domain: i_clk.
- Reset is synchronous and active-high on i_reset; reset is sampled only at posedge i_clk.
- Reset values: all memory words 0, o_valid 0, o_wr_ptr 0, o_count 0. o_wrap is combinational; it is 0 while no lanes are enabled.
- Effective write count k = number of consecutive set bits of i_wr_en starting at lane 0. Lanes above the first zero are ignored, even if set (e.g. 2'b10 -> k=0).
- Lane j < k writes word j to slot (o_wr_ptr + j) mod DEPTH. Writes are visible on o_r_data/o_valid the cycle after the enable edge (1-cycle latency).
- Modulo is computed by conditional subtraction (k <= LANES <= DEPTH, so at most one subtract). No divider.
- o_wr_ptr <= (o_wr_ptr + k) mod DEPTH.
- o_count <= min(o_count + k, DEPTH).
- o_wrap = (k > 0) && (o_wr_ptr + k >= DEPTH). Computed with a width of clog2(DEPTH)+2 bits to avoid overflow.
- Once the dictionary is full, writes overwrite the oldest words in FIFO order. o_valid stays all-ones.
- i_clear (with i_reset low): o_wr_ptr 0, o_count 0, o_valid 0; memory contents retained but marked invalid. Clear has priority over same-cycle writes, which are dropped.
- i_reset has priority over i_clear and over writes; reset mid-burst drops the in-flight writes.
- Slots are distinct within a cycle since k <= DEPTH, so there are no intra-cycle write collisions.
- Unwritten slots hold their value; no other state.

Optional Feature:
- Macro DICT_MATCH_EN.
- When defined, adds the following ports:
  - i_lookup_valid input 1
  - i_lookup_data input DATA_WIDTH
  - o_hit output 1
  - o_hit_idx output clog2(DEPTH)
- Registered lookup, 1-cycle latency:
  - o_hit = i_lookup_valid && some word i has o_valid[i] && memory[i]==i_lookup_data.
  - o_hit_idx = lowest such i, else 0.
- The lookup compares the dictionary state before the same-cycle write (read-before-write).
- o_hit/o_hit_idx reset to 0 on i_reset and on i_clear.
- When not defined, the ports and compare logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single-lane writes, DEPTH=16, LANES=2: write 0xA0..0xAF one per cycle, i_wr_en=2'b01 -> o_count 1..16 then holds 16; o_wrap high only on the 16th write; o_wr_ptr back to 0; o_valid=16'hFFFF.
- Dual-lane wrap from odd pointer: preload ptr=15, i_wr_en=2'b11, data {0x22,0x11} -> slot15=0x11, slot0=0x22; o_wrap=1; o_wr_ptr=1.
- Non-thermometer enable: i_wr_en=2'b10 at ptr=3 -> no slot changes; o_wr_ptr stays 3; o_wrap=0.
- Clear with write: ptr=7, count=7, i_clear=1 and i_wr_en=2'b11 -> next cycle ptr 0, count 0, o_valid 0, memory unchanged.
- Reset mid-operation: assert i_reset during a 2'b11 write at ptr=5 -> next cycle all outputs and memory 0; the write is dropped.
- DICT_MATCH_EN lookup:
  - After writing 0x55 to slots 2 and 9, lookup 0x55 -> o_hit=1, o_hit_idx=2 one cycle later.
  - After i_clear, same lookup -> o_hit=0.
